// File: rtl/mem_bank_if.sv
// Request/response channel between the load/store unit and mem_bank.
// The master issues valid/ready requests; the slave returns one-cycle read pulses.
interface mem_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_bank.sv
// DEPTH x DATA_W word store with byte-enable writes, registered reads and a zeroize sweep.
// Define MEM_PARITY_EN to keep one even-parity bit per byte and flag mismatches on reads.
//
//   state    | meaning
//   ST_CLEAR | sweeping zeros into word[ptr], requests blocked, busy=1
//   ST_IDLE  | serving requests; zeroize starts a new sweep
module mem_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  mem_bank_if.slave    bus,
  input  logic         zeroize,
  output logic         busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                req_ready;

`ifdef MEM_PARITY_EN
  logic [NB-1:0]       par_q [DEPTH];
  logic [NB-1:0]       par_d [DEPTH];
  logic                rsp_err_q, rsp_err_d;

  function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = ^w[8*i +: 8];
    return p;
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mem_d       = mem_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    busy        = 1'b0;
    req_ready   = 1'b0;
`ifdef MEM_PARITY_EN
    par_d     = par_q;
    rsp_err_d = rsp_err_q;
`endif
    case (state_q)
      ST_CLEAR: begin
        busy         = 1'b1;
        mem_d[ptr_q] = '0;
`ifdef MEM_PARITY_EN
        par_d[ptr_q] = '0;
`endif
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        req_ready = ~zeroize;
        if (zeroize) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else if (bus.req_valid) begin
          if (bus.req_we) begin
            for (int i = 0; i < NB; i++) begin
              if (bus.req_be[i]) begin
                mem_d[bus.req_addr][8*i +: 8] = bus.req_wdata[8*i +: 8];
`ifdef MEM_PARITY_EN
                par_d[bus.req_addr][i] = ^bus.req_wdata[8*i +: 8];
`endif
              end
            end
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = mem_q[bus.req_addr];
`ifdef MEM_PARITY_EN
            rsp_err_d = |(byte_par(mem_q[bus.req_addr]) ^ par_q[bus.req_addr]);
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Storage is deliberately left alone by reset; the CLEAR sweep wipes it.
  always_ff @(posedge clk) begin
    if (!reset) mem_q <= mem_d;
  end

`ifdef MEM_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) rsp_err_q <= 1'b0;
    else       rsp_err_q <= rsp_err_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) par_q <= par_d;
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_mem_bank.sv
// Self-checking bench for mem_bank: directed scenarios plus random traffic
// compared every cycle against a word-array reference model.
module tb_mem_bank;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NB    = 4;

  logic clk = 1'b0;
  logic reset;
  logic zeroize;
  logic busy;

  mem_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_bank #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .zeroize (zeroize),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [DW-1:0] mem_m [DEPTH];
  logic [NB-1:0] bad_m [DEPTH];
  logic          busy_m = 1'b1;
  int            clear_left = 0;
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_err = 1'b0;
  logic          acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic wipe_model();
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0;
      bad_m[i] = '0;
    end
  endtask

  task automatic cycle(input logic rst, input logic v, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [NB-1:0] be, input logic z);
    reset         = rst;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
    zeroize       = z;
    acc = !rst && !busy_m && !z && v;
    @(posedge clk);
    exp_valid = 1'b0;
    if (rst) begin
      busy_m     = 1'b1;
      clear_left = DEPTH;
      exp_rdata  = '0;
      exp_err    = 1'b0;
      wipe_model();
    end else if (busy_m) begin
      clear_left--;
      if (clear_left == 0) busy_m = 1'b0;
    end else if (z) begin
      busy_m     = 1'b1;
      clear_left = DEPTH;
      wipe_model();
    end else if (v) begin
      if (we) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) begin
            mem_m[a][8*i +: 8] = d[8*i +: 8];
            bad_m[a][i] = 1'b0;
          end
        end
      end else begin
        exp_valid = 1'b1;
        exp_rdata = mem_m[a];
        exp_err   = |bad_m[a];
      end
    end
    #1;
    check("busy",      {31'd0, busy},          {31'd0, busy_m});
    check("req_ready", {31'd0, bus.req_ready}, {31'd0, !busy_m && !z});
    check("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, exp_valid});
    check("rsp_rdata", bus.rsp_rdata,          exp_rdata);
    check("rsp_err",   {31'd0, bus.rsp_err},   {31'd0, exp_err});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    cycle(1'b0, 1'b1, 1'b1, a, d, be, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cycle(1'b0, 1'b1, 1'b0, a, '0, '0, 1'b0);
  endtask

  // Counts post-edge busy observations of a sweep that was entered on the previous edge;
  // zeroize is pulsed once mid-sweep to confirm it is ignored there.
  task automatic measure_busy(output int nb);
    nb = busy ? 1 : 0;
    for (int k = 0; k < 40 && busy; k++) begin
      cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, k == 5);
      if (busy) nb++;
    end
  endtask

  initial begin
    int nr;
    int nb;
    int pulses;
    reset = 1'b1; zeroize = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_be = '0;

    // reset, then a read of addr 3 held until accepted
    cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 4'd3, '0, '0, 1'b0);
    check("rst_rdata", bus.rsp_rdata, 32'h0);
    nr = 0;
    acc = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 4'd3, '0, '0, 1'b0);
      if (!acc) nr++;
    end
    check("ready_wait", nr, 16);
    check("rd3_valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("rd3_data", bus.rsp_rdata, 32'h0);
    idle(1);

    // byte-enable merge and back-to-back write/read
    wr(4'd5, 32'hDEADBEEF, 4'hF);
    wr(4'd5, 32'h000000AA, 4'h1);
    rd(4'd5);
    check("rmw5", bus.rsp_rdata, 32'hDEADBEAA);
    wr(4'd6, 32'h11223344, 4'hF);
    rd(4'd6);
    check("b2b6", bus.rsp_rdata, 32'h11223344);
    wr(4'd6, 32'hFFFFFFFF, 4'h0);
    rd(4'd6);
    check("be0_noop", bus.rsp_rdata, 32'h11223344);

    // fill then stream reads with no bubbles
    for (int a = 0; a < DEPTH; a++) wr(AW'(a), 32'h01010101 * a, 4'hF);
    pulses = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd(AW'(a));
      if (bus.rsp_valid) pulses++;
    end
    check("stream_pulses", pulses, 16);

    // zeroize beats a same-cycle write; mid-sweep zeroize ignored
    cycle(1'b0, 1'b1, 1'b1, 4'd2, 32'hCAFEF00D, 4'hF, 1'b1);
    measure_busy(nb);
    check("zclr_len", nb, 16);
    for (int a = 0; a < DEPTH; a++) begin
      rd(AW'(a));
      check("zero_rd", bus.rsp_rdata, 32'h0);
    end

    // reset at clear cycle 7 restarts the full sweep
    wr(4'd1, 32'h55AA55AA, 4'hF);
    cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1);
    idle(6);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    measure_busy(nb);
    check("rst_clr_len", nb, 16);
    rd(4'd1);
    check("rst_clr_rd1", bus.rsp_rdata, 32'h0);

`ifdef MEM_PARITY_EN
    wr(4'd9, 32'h12345678, 4'hF);
    wr(4'd8, 32'h0F0F0F0F, 4'hF);
    dut.mem_q[9][0] = ~dut.mem_q[9][0];
    mem_m[9][0]     = ~mem_m[9][0];
    bad_m[9][0]     = 1'b1;
    rd(4'd9);
    check("par_err9", {31'd0, bus.rsp_err}, 32'd1);
    rd(4'd8);
    check("par_ok8", {31'd0, bus.rsp_err}, 32'd0);
    wr(4'd9, 32'h00000077, 4'h1);
    rd(4'd9);
    check("par_fix9", {31'd0, bus.rsp_err}, 32'd0);
`endif

    // random traffic
    for (int k = 0; k < 800; k++) begin
      cycle($urandom_range(0, 255) == 0,
            $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)),
            AW'($urandom_range(0, DEPTH - 1)),
            $urandom,
            NB'($urandom_range(0, 15)),
            $urandom_range(0, 63) == 0);
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_bank.md
# mem_bank

Parametrised, handshaked successor to the 16×32 register memory in the secure core: a DEPTH×DATA_W word store with valid/ready request channel, one-cycle registered read response, per-byte write enables, and a hardware zeroize sequencer that clears every word after reset and on demand. Sits between the core's load/store unit and the register-based data store; zeroize is driven by the security controller on tamper/key-erase events.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words (every address valid)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables for writes (bit i ↔ bits 8i+7:8i); ignored on reads
- rsp_valid  out  1  read data valid (single-cycle pulse, no backpressure)
- rsp_rdata  out  DATA_W  read data; holds last value when rsp_valid=0
- rsp_err  out  1  parity error on the returned word; qualified by rsp_valid
- zeroize  in  1  request full clear (level-sampled)
- busy  out  1  clear sequence in progress

## Operation
- States: CLEAR, IDLE.
- reset=1: state←CLEAR, clear pointer←0, rsp_valid←0, rsp_rdata←0, rsp_err←0. Storage contents not touched by reset itself; CLEAR overwrites them.
- CLEAR: each cycle writes all-zero (and correct parity) to word[ptr], ptr←ptr+1; after writing word DEPTH−1, state←IDLE, ptr←0. busy=1, req_ready=0. zeroize ignored.
- IDLE: busy=0; req_ready = ~zeroize. Handshake = req_valid & req_ready.
  - Write handshake: for each i with req_be[i]=1, byte i of word[req_addr]←req_wdata byte i at the edge; other bytes unchanged. No response. req_be=0 is a legal no-op.
  - Read handshake: at the edge, rsp_rdata←word[req_addr], rsp_valid←1 for one cycle.
  - zeroize=1 in IDLE: state←CLEAR next edge; any same-cycle request is not accepted (zeroize wins).
- Back-to-back requests accepted every cycle in IDLE; read of an address written in the immediately preceding accepted cycle returns the new data.
- reset during CLEAR restarts the sequence at word 0.
- req_valid without req_ready: request is not consumed; requester holds it.

## Timing
- Reset outputs: req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Clear duration: exactly DEPTH cycles in CLEAR; req_ready first 1 in the cycle after the DEPTH-th clear edge (DEPTH+1 edges after last reset cycle).
- Read latency: 1 cycle (handshake at edge N → rsp_valid high N..N+1).
- Write visible to a read accepted at the next edge.
- zeroize asserted in IDLE at edge N → busy=1 after N; IDLE again after DEPTH further edges.
- rsp_valid can never be high while busy, except the cycle following a read accepted in the same cycle zeroize… (impossible: zeroize blocks acceptance).

## Configuration
- MEM_PARITY_EN defined: one even-parity bit stored per byte; computed on each byte write and on clear; on read, rsp_err←1 if any byte's parity mismatches, registered with rsp_rdata.
- Not defined: no parity storage; rsp_err tied 0.

## Test plan
- Reset, then hold req_valid=1 read addr 3 → req_ready low for 16 cycles, then read returns rsp_rdata=0x00000000 one cycle after acceptance.
- Write 0xDEADBEEF to addr 5 (be=0xF), write 0x000000AA be=0x1 to addr 5, read 5 → 0xDEADBEAA; back-to-back write/read same address returns new data.
- Interleaved reads of addrs 0–15 every cycle after writing addr*0x01010101 → 16 consecutive rsp_valid pulses with matching data, no bubbles.
- zeroize asserted same cycle as write to addr 2 → write not accepted, busy 16 cycles, all words read 0 afterwards; zeroize during CLEAR ignored; reset at clear cycle 7 → full 16-cycle clear restarts.
- MEM_PARITY_EN: write 0x12345678 addr 9, force-flip stored bit 0 of addr 9, read → rsp_err=1; read unflipped addr 8 → rsp_err=0; without macro rsp_err always 0.
